rs_pp_sink_fifo: RTL and testbench
==================================

RS_PP_SINK_FIFO -- requirements
Module: rs_pp_sink_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, storage entries; power of two, >= 4.
REQ-003 SHALL have parameter GRACE_PERIOD, default 4: upstream round-trip latency (pipeline FF stages forward plus back) absorbed after full_n drops; 1 <= GRACE_PERIOD < DEPTH.
REQ-004 SHALL have ports: clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have ports: rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: if_din  input  DATA_WIDTH  payload from pipeline tail.
REQ-007 SHALL have ports: if_write  input  1  payload valid from pipeline tail.
REQ-008 SHALL have ports: if_full_n  output  1  registered credit, sent back up the pipeline.
REQ-009 SHALL have ports: if_dout  output  DATA_WIDTH  head-of-queue data.
REQ-010 SHALL have ports: if_empty_n  output  1  head data valid.
REQ-011 SHALL have ports: if_read  input  1  consumer pops head when if_empty_n=1.
REQ-012 SHALL have ports: overflow  output  1  sticky error flag (see Configuration).

Function
REQ-013 SHALL accept every cycle with if_write=1 regardless of if_full_n; if_full_n is advisory, delayed by the pipeline.
REQ-014 SHALL keep occupancy count 0..DEPTH; count += write_accepted - read_accepted each cycle.
REQ-015 SHALL drive if_full_n registered: 0 in cycle after count_next >= DEPTH-GRACE_PERIOD, else 1.
REQ-016 SHALL present if_dout/if_empty_n first-word-fall-through: word written at cycle N visible at N+1 with if_empty_n=1.
REQ-017 SHALL hold if_dout stable while if_empty_n=1 and if_read=0.
REQ-018 SHALL ignore if_read when if_empty_n=0 (no pointer/count change).
REQ-019 SHALL, on simultaneous write and read with count=0, accept write; read ignored (not yet visible).
REQ-020 SHALL, on simultaneous write and read with count=DEPTH, accept both; count unchanged, no overflow.
REQ-021 SHALL, on write with count=DEPTH and no read, drop the word, leave state unchanged, set overflow.
REQ-022 SHALL wrap read/write pointers modulo DEPTH using log2(DEPTH)-bit pointers.
REQ-023 SHALL preserve strict FIFO order; no data reordering or duplication.

Reset
REQ-024 SHALL, on rst_n=0 (asynchronous assert), clear pointers and count, drive if_full_n=0, if_empty_n=0, overflow=0; if_dout value is don't-care.
REQ-025 SHALL raise if_full_n=1 on first clk edge after rst_n deassertion (synchronously released).
REQ-026 SHALL discard all stored data on reset mid-operation; if_write during reset is ignored.

Configuration
REQ-027 SHALL with macro RS_PP_OVERFLOW_DETECT_EN defined: implement sticky overflow register, cleared only by reset.
REQ-028 SHALL without RS_PP_OVERFLOW_DETECT_EN: tie overflow to 0, still drop words per REQ-021.

Structure
REQ-029 SHALL place shared constants (default GRACE_PERIOD per pipeline level, pointer-width function) in package rs_pp_pkg.
REQ-030 SHALL instantiate storage as one sub-module rs_pp_sdp_ram (simple dual-port, 1 write, 1 async-read port, DEPTH x DATA_WIDTH).

Verification (DATA_WIDTH=32, DEPTH=16, GRACE_PERIOD=4)
REQ-031 SHALL cover: reset release, write 0xA5A5_0001 at cycle 5 -> if_empty_n=1, if_dout=0xA5A5_0001 at cycle 6; if_full_n=1 throughout.
REQ-032 SHALL cover: 12 back-to-back writes, no reads -> if_full_n=0 from cycle after 12th write; 4 further writes accepted, count=16, overflow=0.
REQ-033 SHALL cover: 17th write at count=16 with no read -> word dropped, overflow=1 sticky (macro on) / 0 (macro off); readback yields first 16 words in order.
REQ-034 SHALL cover: count=16, simultaneous write 0xDEAD_BEEF and read -> count stays 16, 0xDEAD_BEEF is 16th word out, overflow=0.
REQ-035 SHALL cover: 40 writes with random reads (pointer wrap twice) -> output sequence equals input sequence, count returns 0, if_empty_n=0.
REQ-036 SHALL cover: rst_n asserted mid-stream at count=7 -> if_empty_n=0, if_full_n=0 immediately (asynchronous), count=0 after release.

Source files
------------

// File: rtl/rs_pp_pkg.sv
// Shared constants and helpers for the pipeline sink FIFO.
// Provides the default grace period and the pointer-width function.
package rs_pp_pkg;

    // One register forward plus one register back per pipeline level.
    localparam int GRACE_PER_LEVEL      = 2;
    localparam int DEFAULT_LEVELS       = 2;
    localparam int DEFAULT_GRACE_PERIOD = GRACE_PER_LEVEL * DEFAULT_LEVELS;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/rs_pp_sdp_ram.sv
// Simple dual-port storage: one synchronous write port, one async read port.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (combinational read).
module rs_pp_sdp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rs_pp_sink_fifo.sv
// Sink FIFO at the tail of a credit-less pipeline: accepts every write, raises
// a registered early-full credit GRACE_PERIOD entries before the real limit.
// Ports: clk, rst_n (async low); if_din/if_write/if_full_n (upstream side);
// if_dout/if_empty_n/if_read (FWFT consumer side); overflow (sticky error).
// Optional macro RS_PP_OVERFLOW_DETECT_EN enables the sticky overflow flag;
// without it overflow is tied low (words are still dropped when full).
module rs_pp_sink_fifo
    import rs_pp_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 16,
    parameter int GRACE_PERIOD = DEFAULT_GRACE_PERIOD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] if_din,
    input  logic                  if_write,
    output logic                  if_full_n,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    input  logic                  if_read,
    output logic                  overflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] CNT_THR  = (PW+1)'(DEPTH - GRACE_PERIOD);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [PW:0]   count_next;
    logic          full_n_q;
    logic          rd_acc;
    logic          wr_acc;

    // A read is only honoured on a visible head; a write at full is only
    // honoured when a read frees the slot in the same cycle.
    always_comb begin
        rd_acc     = if_read && (count != '0);
        wr_acc     = if_write && ((count != CNT_FULL) || rd_acc);
        count_next = count;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full_n_q <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            count    <= count_next;
            full_n_q <= (count_next < CNT_THR);
        end
    end

    rs_pp_sdp_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .AW        (PW)
    ) u_ram (
        .clk  (clk),
        .we   (wr_acc),
        .waddr(wr_ptr),
        .wdata(if_din),
        .raddr(rd_ptr),
        .rdata(if_dout)
    );

    assign if_full_n  = full_n_q;
    assign if_empty_n = (count != '0);

`ifdef RS_PP_OVERFLOW_DETECT_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (if_write && !wr_acc) begin
            ovf_q <= 1'b1;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_rs_pp_sink_fifo.sv
// Directed self-checking bench for rs_pp_sink_fifo (32 x 16, grace 4).
// Expected overflow follows RS_PP_OVERFLOW_DETECT_EN.
module tb_rs_pp_sink_fifo;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_din;
    logic        if_write;
    logic        if_full_n;
    logic [31:0] if_dout;
    logic        if_empty_n;
    logic        if_read;
    logic        overflow;

    int tests;
    int fails;

`ifdef RS_PP_OVERFLOW_DETECT_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    rs_pp_sink_fifo #(
        .DATA_WIDTH  (32),
        .DEPTH       (16),
        .GRACE_PERIOD(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_din    (if_din),
        .if_write  (if_write),
        .if_full_n (if_full_n),
        .if_dout   (if_dout),
        .if_empty_n(if_empty_n),
        .if_read   (if_read),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic w, input logic [31:0] d, input logic r);
        if_write = w;
        if_din   = d;
        if_read  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        rst_n = 1'b1;
        cyc(1'b0, 32'h0, 1'b0);
    endtask

    logic [31:0] q[$];
    int          written;
    int          popped;
    int          guard;
    logic        w;
    logic        r;
    logic [31:0] d;

    initial begin
        tests    = 0;
        fails    = 0;
        rst_n    = 1'b0;
        if_write = 1'b0;
        if_read  = 1'b0;
        if_din   = '0;

        // Reset state
        #2;
        check("rst_empty_n", 32'(if_empty_n), 32'd0);
        check("rst_full_n", 32'(if_full_n), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        rst_n = 1'b1;
        check("pre_release_full_n", 32'(if_full_n), 32'd0);
        cyc(1'b0, 32'h0, 1'b0);
        check("release_full_n", 32'(if_full_n), 32'd1);

        // Single write, FWFT visibility
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b1, 32'hA5A5_0001, 1'b0);
        check("one_empty_n", 32'(if_empty_n), 32'd1);
        check("one_dout", if_dout, 32'hA5A5_0001);
        check("one_full_n", 32'(if_full_n), 32'd1);
        cyc(1'b0, 32'h0, 1'b0);
        check("one_hold", if_dout, 32'hA5A5_0001);
        cyc(1'b0, 32'h0, 1'b1);
        check("one_drained", 32'(if_empty_n), 32'd0);
        cyc(1'b0, 32'h0, 1'b1);
        check("empty_read_ignored", 32'(if_empty_n), 32'd0);

        // Simultaneous write+read while empty: write lands, read ignored
        cyc(1'b1, 32'h5555_0000, 1'b1);
        check("wr_rd_empty_n", 32'(if_empty_n), 32'd1);
        check("wr_rd_empty_dout", if_dout, 32'h5555_0000);
        cyc(1'b0, 32'h0, 1'b1);
        check("wr_rd_empty_drain", 32'(if_empty_n), 32'd0);

        // Fill: credit drops after 12th write, 4 more accepted, 17th dropped
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 32'h1000_0000 + 32'(i), 1'b0);
            if (i == 10) check("fill11_full_n", 32'(if_full_n), 32'd1);
            if (i == 11) check("fill12_full_n", 32'(if_full_n), 32'd0);
        end
        check("fill16_full_n", 32'(if_full_n), 32'd0);
        check("fill16_overflow", 32'(overflow), 32'd0);
        cyc(1'b1, 32'hBAD0_BAD0, 1'b0);
        check("ovf_set", 32'(overflow), 32'(OVF_EXP));
        cyc(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            check("fill_readback", if_dout, 32'h1000_0000 + 32'(i));
            cyc(1'b0, 32'h0, 1'b1);
        end
        cyc(1'b0, 32'h0, 1'b0);
        check("fill_drained", 32'(if_empty_n), 32'd0);
        check("fill_full_n_back", 32'(if_full_n), 32'd1);
        check("ovf_sticky", 32'(overflow), 32'(OVF_EXP));

        // Full with simultaneous write+read
        do_reset();
        check("reset_clears_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) cyc(1'b1, 32'h2000_0000 + 32'(i), 1'b0);
        cyc(1'b1, 32'hDEAD_BEEF, 1'b1);
        check("full_wr_rd_ovf", 32'(overflow), 32'd0);
        check("full_wr_rd_full_n", 32'(if_full_n), 32'd0);
        cyc(1'b0, 32'h0, 1'b0);
        for (int i = 1; i < 16; i++) begin
            check("full_wr_rd_data", if_dout, 32'h2000_0000 + 32'(i));
            cyc(1'b0, 32'h0, 1'b1);
        end
        check("deadbeef_16th", if_dout, 32'hDEAD_BEEF);
        cyc(1'b0, 32'h0, 1'b1);
        check("deadbeef_drained", 32'(if_empty_n), 32'd0);
        check("deadbeef_ovf", 32'(overflow), 32'd0);

        // 40 writes with random reads against a queue model
        written = 0;
        popped  = 0;
        guard   = 0;
        q.delete();
        while ((written < 40 || q.size() != 0) && guard < 2000) begin
            w = (written < 40) && (q.size() < 14) && ($urandom_range(3) != 0);
            r = ($urandom_range(1) == 1) || (written >= 40);
            d = 32'h3000_0000 + 32'(written * 7);
            check("rand_empty_n", 32'(if_empty_n), 32'(q.size() != 0));
            if (r && q.size() != 0) check("rand_dout", if_dout, q[0]);
            cyc(w, d, r);
            if (r && q.size() != 0) begin
                void'(q.pop_front());
                popped++;
            end
            if (w) begin
                q.push_back(d);
                written++;
            end
            guard++;
        end
        cyc(1'b0, 32'h0, 1'b0);
        check("rand_timeout", 32'(guard < 2000), 32'd1);
        check("rand_popped", 32'(popped), 32'd40);
        check("rand_final_empty", 32'(if_empty_n), 32'd0);

        // Asynchronous reset mid-stream at count 7
        for (int i = 0; i < 7; i++) cyc(1'b1, 32'h4000_0000 + 32'(i), 1'b0);
        if_write = 1'b0;
        check("pre_rst_empty_n", 32'(if_empty_n), 32'd1);
        #2;
        rst_n    = 1'b0;
        if_write = 1'b1;
        if_din   = 32'hFFFF_FFFF;
        #1;
        check("async_empty_n", 32'(if_empty_n), 32'd0);
        check("async_full_n", 32'(if_full_n), 32'd0);
        @(posedge clk);
        #1;
        check("in_rst_write_ignored", 32'(if_empty_n), 32'd0);
        rst_n = 1'b1;
        cyc(1'b0, 32'h0, 1'b0);
        check("post_rst_empty_n", 32'(if_empty_n), 32'd0);
        check("post_rst_full_n", 32'(if_full_n), 32'd1);
        cyc(1'b1, 32'h5000_0001, 1'b0);
        check("post_rst_dout", if_dout, 32'h5000_0001);
        cyc(1'b0, 32'h0, 1'b1);
        check("post_rst_drain", 32'(if_empty_n), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
